// File: rtl/vsfx_pipe.sv
// Two-stage vector simple fixed-point unit: add/sub/avg/compare/shift on
// byte, half or word lanes with sticky saturation, CR6 and illegal flagging.
module vsfx_pipe #(
  parameter int VLEN = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            stall,
  input  logic [VLEN-1:0] vra,
  input  logic [VLEN-1:0] vrb,
  input  logic [7:0]      ins,
  input  logic            sat_clr,
  output logic            vrt_en,
  output logic [VLEN-1:0] vrt,
  output logic            sat,
  output logic [3:0]      cr6,
  output logic            ill
);

  // Returns {lane_sat, lane_eq, result}; operands are zero-extended n-bit lanes.
  function automatic logic [33:0] lane_op(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int unsigned n);
    logic [33:0]        mask, ua, ub, r, sbit;
    logic signed [33:0] sa, sb, s, smax, smin;
    logic               lsat, eq;
    logic [4:0]         shamt;
    mask  = (34'd1 << n) - 34'd1;
    sbit  = 34'd1 << (n - 1);
    ua    = {2'b00, a} & mask;
    ub    = {2'b00, b} & mask;
    sa    = $signed(ua);
    sb    = $signed(ub);
    if ((ua & sbit) != 34'd0) sa = sa - $signed(mask) - 34'sd1;
    if ((ub & sbit) != 34'd0) sb = sb - $signed(mask) - 34'sd1;
    smax  = $signed(sbit - 34'd1);
    smin  = -smax - 34'sd1;
    shamt = ub[4:0] & 5'(n - 1);
    s     = '0;
    r     = '0;
    lsat  = 1'b0;
    eq    = (ua == ub);
    case (op)
      3'b000: r = ua + ub;
      3'b001: begin
        s = sa + sb;
        if (s > smax) begin
          r    = $unsigned(smax);
          lsat = 1'b1;
        end else if (s < smin) begin
          r    = $unsigned(smin);
          lsat = 1'b1;
        end else begin
          r = $unsigned(s);
        end
      end
      3'b010: begin
        r = ua + ub;
        if (r > mask) begin
          r    = mask;
          lsat = 1'b1;
        end
      end
      3'b011: r = ua - ub;
      3'b100: begin
        // Extra headroom bits mean the +1 rounding never overflows.
        s = (sa + sb + 34'sd1) >>> 1;
        r = $unsigned(s);
      end
      3'b101: r = eq ? mask : 34'd0;
      3'b110: r = ua << shamt;
      default: r = '0;
    endcase
    return {lsat, eq, r[31:0] & mask[31:0]};
  endfunction

  logic [2:0] op_d;
  logic [1:0] size_d;
  logic       rc_d, ill_d, adv;

  assign op_d   = ins[7:5];
  assign size_d = ins[4:3];
  assign rc_d   = ins[0];
  assign ill_d  = (op_d == 3'b111) || (size_d == 2'b11) || (ins[2:1] != 2'b00) ||
                  (rc_d && (op_d != 3'b101));
  assign adv    = !stall;

  logic [VLEN-1:0] res_b, res_h, res_w, res_d;
  logic            sat_b, sat_h, sat_w, sat_sel;
  logic            alleq_b, alleq_h, alleq_w, alleq_sel;
  logic            anyeq_b, anyeq_h, anyeq_w, anyeq_sel;
  logic [33:0]     lr;

  always_comb begin
    res_b = '0; res_h = '0; res_w = '0;
    sat_b = 1'b0; sat_h = 1'b0; sat_w = 1'b0;
    alleq_b = 1'b1; alleq_h = 1'b1; alleq_w = 1'b1;
    anyeq_b = 1'b0; anyeq_h = 1'b0; anyeq_w = 1'b0;
    lr = '0;
    for (int i = 0; i < VLEN/8; i++) begin
      lr = lane_op(op_d, {24'd0, vra[i*8 +: 8]}, {24'd0, vrb[i*8 +: 8]}, 8);
      res_b[i*8 +: 8] = lr[7:0];
      sat_b   = sat_b | lr[33];
      alleq_b = alleq_b & lr[32];
      anyeq_b = anyeq_b | lr[32];
    end
    for (int i = 0; i < VLEN/16; i++) begin
      lr = lane_op(op_d, {16'd0, vra[i*16 +: 16]}, {16'd0, vrb[i*16 +: 16]}, 16);
      res_h[i*16 +: 16] = lr[15:0];
      sat_h   = sat_h | lr[33];
      alleq_h = alleq_h & lr[32];
      anyeq_h = anyeq_h | lr[32];
    end
    for (int i = 0; i < VLEN/32; i++) begin
      lr = lane_op(op_d, vra[i*32 +: 32], vrb[i*32 +: 32], 32);
      res_w[i*32 +: 32] = lr[31:0];
      sat_w   = sat_w | lr[33];
      alleq_w = alleq_w & lr[32];
      anyeq_w = anyeq_w | lr[32];
    end
    case (size_d)
      2'b00:   begin res_d = res_b; sat_sel = sat_b; alleq_sel = alleq_b; anyeq_sel = anyeq_b; end
      2'b01:   begin res_d = res_h; sat_sel = sat_h; alleq_sel = alleq_h; anyeq_sel = anyeq_h; end
      default: begin res_d = res_w; sat_sel = sat_w; alleq_sel = alleq_w; anyeq_sel = anyeq_w; end
    endcase
  end

  logic            v1, ill1, rc1, sat1, alleq1, anyeq1;
  logic [2:0]      op1;
  logic [VLEN-1:0] res1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      ill1   <= 1'b0;
      rc1    <= 1'b0;
      sat1   <= 1'b0;
      alleq1 <= 1'b0;
      anyeq1 <= 1'b0;
      op1    <= '0;
      res1   <= '0;
    end else if (adv) begin
      v1 <= en;
      if (en) begin
        ill1   <= ill_d;
        rc1    <= rc_d;
        op1    <= op_d;
        sat1   <= sat_sel;
        alleq1 <= alleq_sel;
        anyeq1 <= anyeq_sel;
        res1   <= res_d;
      end
    end
  end

  logic retire, sat_set, cr_upd;

  assign retire  = adv && v1;
  assign sat_set = retire && !ill1 && sat1;
  assign cr_upd  = retire && !ill1 && rc1 && (op1 == 3'b101);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vrt_en <= 1'b0;
      vrt    <= '0;
      sat    <= 1'b0;
      cr6    <= '0;
      ill    <= 1'b0;
    end else begin
      // Set wins over a coincident clear.
      sat <= (sat && !sat_clr) || sat_set;
      if (adv) begin
        vrt_en <= v1;
        ill    <= v1 && ill1;
        if (v1) vrt <= ill1 ? '0 : res1;
      end
      if (cr_upd) cr6 <= {alleq1, 1'b0, !anyeq1, 1'b0};
    end
  end

endmodule

// File: tb/tb_vsfx_pipe.sv
// Directed bench for vsfx_pipe at VLEN=128 with hand-computed expectations.
module tb_vsfx_pipe;
  logic         clk = 1'b0;
  logic         rst_n, en, stall, sat_clr;
  logic [127:0] vra, vrb;
  logic [7:0]   ins;
  logic         vrt_en, sat, ill;
  logic [127:0] vrt;
  logic [3:0]   cr6;

  int errors = 0;
  int checks = 0;

  vsfx_pipe #(.VLEN(128)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .vra(vra), .vrb(vrb),
    .ins(ins), .sat_clr(sat_clr), .vrt_en(vrt_en), .vrt(vrt), .sat(sat),
    .cr6(cr6), .ill(ill)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rep8(input logic [7:0] x);   return {16{x}}; endfunction
  function automatic logic [127:0] rep16(input logic [15:0] x); return {8{x}};  endfunction
  function automatic logic [127:0] rep32(input logic [31:0] x); return {4{x}};  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] i, input logic [127:0] a, input logic [127:0] b);
    en = 1'b1; ins = i; vra = a; vrb = b;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_one(input logic [7:0] i, input logic [127:0] a, input logic [127:0] b);
    drive(i, a, b);
    tick();
    en = 1'b0;
    tick();
  endtask

  task automatic clear_sat();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
  endtask

  logic [7:0]   si [3];
  logic [127:0] sa [3];
  logic [127:0] sb [3];
  logic [127:0] se [3];
  logic [7:0]   bad [4];

  initial begin
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; sat_clr = 1'b0;
    vra = '0; vrb = '0; ins = '0;
    si[0] = 8'b011_00_00_0; sa[0] = '0;                 sb[0] = rep8(8'h01);
    se[0] = rep8(8'hFF);
    si[1] = 8'b110_01_00_0; sa[1] = rep16(16'h0001);    sb[1] = rep16(16'h0011);
    se[1] = rep16(16'h0002);
    si[2] = 8'b010_10_00_0; sa[2] = rep32(32'hFFFFFFF0); sb[2] = rep32(32'h00000020);
    se[2] = rep32(32'hFFFFFFFF);
    bad[0] = 8'b111_00_00_0; bad[1] = 8'b001_11_00_0;
    bad[2] = 8'b001_00_00_1; bad[3] = 8'b101_00_01_1;

    tick(); tick();
    chk("rst_vrt_en", 128'(vrt_en), 128'd0);
    chk("rst_vrt", vrt, '0);
    chk("rst_sat", 128'(sat), 128'd0);
    chk("rst_cr6", 128'(cr6), 128'd0);
    chk("rst_ill", 128'(ill), 128'd0);
    rst_n = 1'b1;
    tick();

    run_one(8'b001_00_00_0, rep8(8'h7F), rep8(8'h01));
    chk("ssat_en", 128'(vrt_en), 128'd1);
    chk("ssat_vrt", vrt, rep8(8'h7F));
    chk("ssat_sat", 128'(sat), 128'd1);
    run_one(8'b000_00_00_0, rep8(8'h01), rep8(8'h01));
    chk("addm_vrt", vrt, rep8(8'h02));
    chk("addm_sat_sticky", 128'(sat), 128'd1);
    clear_sat();
    chk("sat_clr", 128'(sat), 128'd0);

    run_one(8'b101_01_00_1, rep16(16'h1234), rep16(16'h1234));
    chk("cmpeq_vrt", vrt, {128{1'b1}});
    chk("cmpeq_cr6", 128'(cr6), 128'd8);
    run_one(8'b101_01_00_1, rep16(16'h1234), '0);
    chk("cmpne_vrt", vrt, '0);
    chk("cmpne_cr6", 128'(cr6), 128'd2);
    chk("cmpne_ill", 128'(ill), 128'd0);

    run_one(8'b100_10_00_0, rep32(32'hFFFFFFFF), rep32(32'h00000002));
    chk("avg_neg", vrt, rep32(32'h00000001));
    run_one(8'b100_10_00_0, rep32(32'h7FFFFFFF), rep32(32'h7FFFFFFF));
    chk("avg_max", vrt, rep32(32'h7FFFFFFF));
    chk("avg_cr6_hold", 128'(cr6), 128'd2);

    for (int k = 0; k < 3; k++) begin
      drive(si[k], sa[k], sb[k]);
      tick();
      if (k >= 1) begin
        chk("b2b_en", 128'(vrt_en), 128'd1);
        chk("b2b_vrt", vrt, se[k-1]);
      end
    end
    en = 1'b0;
    tick();
    chk("b2b_last", vrt, se[2]);
    chk("b2b_sat", 128'(sat), 128'd1);
    tick();
    chk("bubble_en", 128'(vrt_en), 128'd0);
    chk("bubble_hold", vrt, se[2]);

    drive(si[0], sa[0], sb[0]); tick();
    drive(si[1], sa[1], sb[1]); tick();
    chk("st_pre", vrt, se[0]);
    drive(si[2], sa[2], sb[2]);
    stall = 1'b1; sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("st1_vrt", vrt, se[0]);
    chk("st1_en", 128'(vrt_en), 128'd1);
    chk("st1_satclr", 128'(sat), 128'd0);
    tick();
    chk("st2_vrt", vrt, se[0]);
    stall = 1'b0;
    tick();
    chk("st_res1", vrt, se[1]);
    en = 1'b0;
    tick();
    chk("st_res2", vrt, se[2]);
    chk("st_sat", 128'(sat), 128'd1);
    tick();
    chk("st_drain", 128'(vrt_en), 128'd0);

    clear_sat();
    for (int k = 0; k < 4; k++) begin
      run_one(bad[k], rep8(8'h7F), rep8(8'h7F));
      chk("ill_en", 128'(vrt_en), 128'd1);
      chk("ill_flag", 128'(ill), 128'd1);
      chk("ill_vrt", vrt, '0);
      chk("ill_sat", 128'(sat), 128'd0);
      chk("ill_cr6", 128'(cr6), 128'd2);
    end

    drive(8'b000_00_00_0, rep8(8'h01), rep8(8'h01)); tick();
    drive(8'b000_00_00_0, rep8(8'h02), rep8(8'h02)); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", 128'(vrt_en), 128'd0);
    chk("arst_vrt", vrt, '0);
    chk("arst_cr6", 128'(cr6), 128'd0);
    chk("arst_ill", 128'(ill), 128'd0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arst_quiet", 128'(vrt_en), 128'd0);
    end
    run_one(8'b000_00_00_0, rep8(8'h01), rep8(8'h02));
    chk("post_rst_en", 128'(vrt_en), 128'd1);
    chk("post_rst_vrt", vrt, rep8(8'h03));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vsfx_pipe.md
Name: vsfx_pipe

Overview:
- Parametrised, pipelined successor of the single-cycle vector simple fixed-point unit.
- Executes integer add, subtract, average, compare and shift-left on VLEN-bit vectors.
- Element size is byte, half or word, selected per instruction.
- Two-stage pipeline with a stall input, sticky saturation bit, recorded-compare CR6 generation and illegal-instruction flagging.
- Sits between the vector register file read port and the writeback arbiter.

Parameters:
VLEN, 128, vector width in bits; must be a multiple of 32 (32..512).

Ports:
clk      in   1     clock, all state on rising edge
rst_n    in   1     asynchronous active-low reset
en       in   1     instruction valid this cycle
stall    in   1     1 = hold both pipeline stages
vra      in   VLEN  operand A
vrb      in   VLEN  operand B
ins      in   8     [7:5] op, [4:3] element size, [2:1] must be 00, [0] rc
sat_clr  in   1     clear sticky sat (mtvscr path)
vrt_en   out  1     vrt/cr6/ill valid this cycle
vrt      out  VLEN  result
sat      out  1     sticky VSCR[SAT]
cr6      out  4     CR field 6, updated by recorded compares only
ill      out  1     retiring instruction had an illegal encoding

Behaviour:
- Reset (rst_n=0, asynchronous): both stage valids 0, vrt_en=0, vrt=0, sat=0, cr6=0, ill=0.
  - Reset mid-operation discards all in-flight instructions; nothing retires.
- Op codes:
  - 000 add modulo
  - 001 add signed saturate
  - 010 add unsigned saturate
  - 011 sub modulo (a-b)
  - 100 avg signed: (a+b+1)>>>1, computed at element width+1, no overflow
  - 101 compare equal: element all-ones if a==b, else 0
  - 110 shift left: a << (b mod element bits), zero fill
  - 111 illegal
- Element size: 00 byte, 01 half, 10 word, 11 illegal. ins[2:1]!=00 is illegal. rc=1 on an op other than 101 is illegal.
- Illegal instruction:
  - Retires with vrt_en=1, ill=1, vrt=0.
  - sat and cr6 are not modified.
- Saturation:
  - Signed: clamp to 2^(n-1)-1 / -2^(n-1).
  - Unsigned: clamp to 2^n-1.
  - Any clamped lane sets the per-instruction sat flag.
- Pipeline:
  - Stage 1 registers the decoded op, per-lane results, lane sat flags and compare summaries.
  - Stage 2 registers the selected vrt and flags.
  - Latency is exactly 2 cycles: en at edge N gives vrt_en=1 after edge N+2.
  - Throughput is 1 instruction per cycle.
  - en=0 inserts a bubble; vrt_en=0 for that slot and vrt holds its last value.
- stall=1:
  - No stage advances, and en is ignored that cycle (the issuer must hold the instruction).
  - vrt, vrt_en, sat and cr6 hold their values.
  - sat_clr is still honoured.
- Sticky sat:
  - Set when a saturating add retires with any lane clamped.
  - Cleared by sat_clr.
  - If sat_clr and a saturating retire happen in the same cycle, the result is sat=1 (set wins).
- cr6: updated only when a legal compare with rc=1 retires.
  - cr6[3] = all elements equal
  - cr6[1] = no element equal
  - cr6[2] = cr6[0] = 0
  - Otherwise cr6 holds.
- Lane layout: element 0 occupies the most-significant bits (big-endian element numbering). Arithmetic is identical per lane regardless of position.

Test Plan:
- Byte add signed sat, VLEN=128: vra lanes 0x7F, vrb lanes 0x01 (ins=001_00_00_0) -> after 2 cycles vrt=0x7F7F...7F, vrt_en=1, sat=1. sat stays 1 across a later add modulo, and sat_clr drops it to 0 the next cycle.
- Half compare recorded: vra=vrb=0x1234 in every lane (ins=101_01_00_1) -> vrt all ones, cr6=4'b1000. Repeat with vrb=0 -> vrt=0, cr6=4'b0010.
- Word avg signed: a=0xFFFFFFFF (-1), b=0x00000002 in every lane -> vrt lanes 0x00000001. Also a=0x7FFFFFFF, b=0x7FFFFFFF -> 0x7FFFFFFF with no overflow.
- Back-to-back issue:
  - Three consecutive en=1 instructions (sub modulo bytes 0x00-0x01=0xFF; shift left half 0x0001 by 17 gives 0x0002; unsigned sat add word 0xFFFFFFF0+0x20 gives 0xFFFFFFFF) -> three consecutive vrt_en pulses in order.
  - With stall=1 for 2 cycles mid-stream: outputs frozen, then resume in order with none lost or duplicated.
- Illegal encodings: op 111, size 11, and rc=1 on add -> each retires with ill=1, vrt=0; sat and cr6 unchanged.
- Assert rst_n=0 asynchronously while two instructions are in flight -> all outputs 0 immediately, and no vrt_en after release until a new en.
